// File: rtl/barrel_shifter_pipe.sv
// ---------------------------------------------------------------------------
// barrel_shifter_pipe
//
// Pipelined barrel shifter with valid/ready handshakes on both sides.
// Supports logical, arithmetic and rotate shifts of a WIDTH-bit word and
// accepts one operation per clock at full throughput.
//
// The pipeline has SHW = $clog2(WIDTH) register stages. Stage k applies a
// shift of 2^k when bit k of the shift amount is set. The op code and the
// shift amount travel down the pipe with the data. Every stage carries its
// own valid bit and a local ready, so bubbles are squeezed out under
// backpressure and in_ready only falls once every stage holds a beat.
//
// Parameters
//   WIDTH      data width, power of two, 4..64
//   SHW        shift-amount width and pipeline depth (derived)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   input beat present
//   in_ready   block accepts the beat this cycle (0 while rst=1)
//   in_data    operand
//   in_shamt   shift amount, 0..WIDTH-1
//   in_op      0 SLL, 1 SRL, 2 ROL, 3 ROR, 4 SRA, 5..7 pass-through
//   out_valid  result present (last-stage register)
//   out_ready  consumer accepts the result
//   out_data   shifted result (last-stage register)
//
// Optional build macro BARREL_FLAGS_EN adds:
//   out_zero   out_data == 0
//   out_carry  last bit shifted out (rotates: the bit that wrapped into the
//              end the rotation moved towards); 0 for shamt 0/pass-through
// ---------------------------------------------------------------------------
module barrel_shifter_pipe #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef BARREL_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_carry
`endif
);

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_ROL = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_SRA = 3'd4;

  // One partial shift by amt (amt < WIDTH). The sign bit is preserved by
  // every SRA step, so the current MSB is always the operand's original MSB.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       op,
    input int               amt
  );
    logic signed [WIDTH-1:0] sd;
    logic        [WIDTH-1:0] r;
    sd = d;
    r  = d;
    case (op)
      OP_SLL:  r = d << amt;
      OP_SRL:  r = d >> amt;
      OP_SRA:  r = sd >>> amt;
      OP_ROL:  r = (d << amt) | (d >> (WIDTH - amt));
      OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
      default: r = d;
    endcase
    return r;
  endfunction

  // Bit that leaves the word during one partial shift. Because stages run in
  // increasing order, the last applied step's carry equals the carry of the
  // whole shift (e.g. SLL: cur[WIDTH-2^k] is in_data[WIDTH-shamt]).
  function automatic logic carry_step(
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] r,
    input logic [2:0]       op,
    input int               amt
  );
    logic [WIDTH-1:0] t;
    logic             c;
    c = 1'b0;
    t = '0;
    case (op)
      OP_SLL: begin
        t = d >> (WIDTH - amt);
        c = t[0];
      end
      OP_SRL, OP_SRA: begin
        t = d >> (amt - 1);
        c = t[0];
      end
      OP_ROL:  c = r[0];
      OP_ROR:  c = r[WIDTH-1];
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  // Stage registers
  logic             vld_p  [SHW];
  logic [WIDTH-1:0] data_p [SHW];
  logic [2:0]       op_p   [SHW];
  logic [SHW-1:0]   sh_p   [SHW];

  // Per-stage upstream view and next value
  logic             up_vld   [SHW];
  logic [WIDTH-1:0] up_data  [SHW];
  logic [2:0]       up_op    [SHW];
  logic [SHW-1:0]   up_sh    [SHW];
  logic [WIDTH-1:0] nxt_data [SHW];

`ifdef BARREL_FLAGS_EN
  logic             cy_p   [SHW];
  logic             up_cy  [SHW];
  logic             nxt_cy [SHW];
  logic             zero_p;
`endif

  // rdy[k] is the ready seen by stage k; rdy[SHW] is the consumer.
  logic [SHW:0] rdy;

  always_comb begin
    rdy      = '0;
    rdy[SHW] = out_ready;
    for (int k = SHW - 1; k >= 0; k--) begin
      rdy[k] = !vld_p[k] || rdy[k+1];
    end
  end

  assign in_ready = rdy[0] && !rst;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int AMT = 1 << k;

    if (k == 0) begin : g_src
      assign up_vld[k]  = in_valid;
      assign up_data[k] = in_data;
      assign up_op[k]   = in_op;
      assign up_sh[k]   = in_shamt;
`ifdef BARREL_FLAGS_EN
      assign up_cy[k]   = 1'b0;
`endif
    end else begin : g_src
      assign up_vld[k]  = vld_p[k-1];
      assign up_data[k] = data_p[k-1];
      assign up_op[k]   = op_p[k-1];
      assign up_sh[k]   = sh_p[k-1];
`ifdef BARREL_FLAGS_EN
      assign up_cy[k]   = cy_p[k-1];
`endif
    end

    assign nxt_data[k] = up_sh[k][k] ? shift_step(up_data[k], up_op[k], AMT)
                                     : up_data[k];

    // ---- stage k register boundary: shift by 2^k applied ----
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p[k]  <= 1'b0;
        data_p[k] <= '0;
        op_p[k]   <= '0;
        sh_p[k]   <= '0;
      end else if (rdy[k]) begin
        vld_p[k] <= up_vld[k];
        if (up_vld[k]) begin
          data_p[k] <= nxt_data[k];
          op_p[k]   <= up_op[k];
          sh_p[k]   <= up_sh[k];
        end
      end
    end

`ifdef BARREL_FLAGS_EN
    assign nxt_cy[k] = up_sh[k][k]
                     ? carry_step(up_data[k], nxt_data[k], up_op[k], AMT)
                     : up_cy[k];

    always_ff @(posedge clk) begin
      if (rst) begin
        cy_p[k] <= 1'b0;
      end else if (rdy[k] && up_vld[k]) begin
        cy_p[k] <= nxt_cy[k];
      end
    end
`endif
  end

`ifdef BARREL_FLAGS_EN
  // ---- last stage: zero flag registered alongside out_data ----
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_p <= 1'b0;
    end else if (rdy[SHW-1] && up_vld[SHW-1]) begin
      zero_p <= (nxt_data[SHW-1] == '0);
    end
  end

  assign out_zero  = zero_p;
  assign out_carry = cy_p[SHW-1];
`endif

  assign out_valid = vld_p[SHW-1];
  assign out_data  = data_p[SHW-1];

  // Op and shift amount are not needed past the final stage.
  logic unused_tail;
  assign unused_tail = ^{op_p[SHW-1], sh_p[SHW-1]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// ---------------------------------------------------------------------------
// tb_barrel_shifter_pipe
//
// Two instances: WIDTH=8 for directed vectors, backpressure and reset
// behaviour; WIDTH=32 for random traffic against a behavioural model.
// Define BARREL_FLAGS_EN for both RTL and bench to cover the flag ports.
// ---------------------------------------------------------------------------
module tb_barrel_shifter_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       iv8, ir8, ov8, or8;
  logic [7:0] id8, od8;
  logic [2:0] is8, io8;

  logic        iv32, ir32, ov32, or32;
  logic [31:0] id32, od32;
  logic [4:0]  is32;
  logic [2:0]  io32;

`ifdef BARREL_FLAGS_EN
  logic oz8, oc8, oz32, oc32;
`endif

  barrel_shifter_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_shamt(is8), .in_op(io8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8)
`ifdef BARREL_FLAGS_EN
    , .out_zero(oz8), .out_carry(oc8)
`endif
  );

  barrel_shifter_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(iv32), .in_ready(ir32), .in_data(id32), .in_shamt(is32), .in_op(io32),
    .out_valid(ov32), .out_ready(or32), .out_data(od32)
`ifdef BARREL_FLAGS_EN
    , .out_zero(oz32), .out_carry(oc32)
`endif
  );

  typedef struct {
    logic [63:0] d;
    int          sh;
    int          op;
    logic [63:0] e;
    logic        c;
  } beat_t;

  typedef struct {
    logic [63:0] e;
    logic        c;
    int          it;
  } exp_t;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: whole-word arithmetic on a 64-bit container.
  function automatic logic [63:0] ref_shift(input logic [63:0] din, input int sh,
                                            input int op, input int w);
    logic [63:0] mask, d, r;
    mask = (64'd1 << w) - 64'd1;
    d    = din & mask;
    case (op)
      0: r = (d << sh) & mask;
      1: r = d >> sh;
      2: r = ((d << sh) | (d >> (w - sh))) & mask;
      3: r = ((d >> sh) | (d << (w - sh))) & mask;
      4: begin
        r = d >> sh;
        if (((d >> (w - 1)) & 64'd1) != 64'd0) r = r | (mask & ~(mask >> sh));
      end
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic ref_carry(input logic [63:0] d, input int sh, input int op,
                                     input int w, input logic [63:0] r);
    if (sh == 0 || op > 4) return 1'b0;
    case (op)
      0:       return 1'((d >> (w - sh)) & 64'd1);
      2:       return 1'(r & 64'd1);
      3:       return 1'((r >> (w - 1)) & 64'd1);
      default: return 1'((d >> (sh - 1)) & 64'd1);
    endcase
  endfunction

  function automatic beat_t mk(input logic [63:0] d, input int sh, input int op,
                               input logic [63:0] e, input logic c);
    beat_t b;
    b.d = d; b.sh = sh; b.op = op; b.e = e; b.c = c;
    return b;
  endfunction

  // ---------------- WIDTH=8 driver / scoreboard ----------------
  beat_t stim8[$];
  exp_t  exp8[$];
  beat_t cur8;
  int    it8 = 0, outs8 = 0, accs8 = 0;
  bit    lat8 = 1'b0;

  task automatic tick8();
    exp_t x;
    logic fin, fout;
    if (!iv8 && stim8.size() > 0) begin
      cur8 = stim8.pop_front();
      id8  = cur8.d[7:0];
      is8  = 3'(cur8.sh);
      io8  = 3'(cur8.op);
      iv8  = 1'b1;
    end
    #1;
    fin  = iv8 && ir8;
    fout = ov8 && or8;
    if (fout) begin
      outs8++;
      if (exp8.size() == 0) begin
        check("unexpected_out8", 64'(exp8.size()), 64'd1);
      end else begin
        x = exp8.pop_front();
        check("data8", 64'(od8), x.e);
`ifdef BARREL_FLAGS_EN
        check("zero8", 64'(oz8), 64'(x.e == 64'd0));
        check("carry8", 64'(oc8), 64'(x.c));
`endif
        if (lat8) check("latency8", 64'(it8 - x.it), 64'd3);
      end
    end
    if (fin) begin
      accs8++;
      x.e  = cur8.e;
      x.c  = cur8.c;
      x.it = it8;
      exp8.push_back(x);
    end
    @(posedge clk);
    #1;
    it8++;
    if (fin) iv8 = 1'b0;
  endtask

  // ---------------- WIDTH=32 random driver / scoreboard ----------------
  exp_t        exp32[$];
  beat_t       cur32;
  int          it32 = 0, outs32 = 0, accs32 = 0, left32 = 0;
  bit          lat32 = 1'b0, rnd32 = 1'b0;
  logic        stall32 = 1'b0;
  logic [31:0] held32 = '0;

  task automatic tick32();
    exp_t        x;
    logic        fin, fout;
    logic [63:0] r;
    if (rnd32) or32 = 1'($urandom_range(0, 1));
    if (!iv32 && left32 > 0 && (!rnd32 || $urandom_range(0, 3) != 0)) begin
      cur32.d  = 64'($urandom);
      cur32.sh = int'($urandom_range(0, 31));
      cur32.op = int'($urandom_range(0, 7));
      r        = ref_shift(cur32.d, cur32.sh, cur32.op, 32);
      cur32.e  = r;
      cur32.c  = ref_carry(cur32.d, cur32.sh, cur32.op, 32, r);
      id32 = cur32.d[31:0];
      is32 = 5'(cur32.sh);
      io32 = 3'(cur32.op);
      iv32 = 1'b1;
      left32--;
    end
    #1;
    if (stall32) begin
      check("hold_valid32", 64'(ov32), 64'd1);
      check("hold_data32", 64'(od32), 64'(held32));
    end
    fin  = iv32 && ir32;
    fout = ov32 && or32;
    if (fout) begin
      outs32++;
      if (exp32.size() == 0) begin
        check("unexpected_out32", 64'(exp32.size()), 64'd1);
      end else begin
        x = exp32.pop_front();
        check("data32", 64'(od32), x.e);
`ifdef BARREL_FLAGS_EN
        check("zero32", 64'(oz32), 64'(x.e == 64'd0));
        check("carry32", 64'(oc32), 64'(x.c));
`endif
        if (lat32) check("latency32", 64'(it32 - x.it), 64'd5);
      end
    end
    stall32 = ov32 && !or32;
    held32  = od32;
    if (fin) begin
      accs32++;
      x.e  = cur32.e;
      x.c  = cur32.c;
      x.it = it32;
      exp32.push_back(x);
    end
    @(posedge clk);
    #1;
    it32++;
    if (fin) iv32 = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    iv8 = 1'b0; id8 = '0; is8 = '0; io8 = '0; or8 = 1'b0;
    iv32 = 1'b0; id32 = '0; is32 = '0; io32 = '0; or32 = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid8", 64'(ov8), 64'd0);
    check("rst_out_data8", 64'(od8), 64'd0);
    check("rst_in_ready8", 64'(ir8), 64'd0);
    check("rst_out_valid32", 64'(ov32), 64'd0);
    check("rst_in_ready32", 64'(ir32), 64'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst8", 64'(ir8), 64'd1);

    // Directed vectors, full rate, latency 3
    or8  = 1'b1;
    lat8 = 1'b1;
    stim8.push_back(mk(64'hB3, 2, 0, 64'hCC, 1'b0));
    stim8.push_back(mk(64'hB3, 2, 1, 64'h2C, 1'b1));
    stim8.push_back(mk(64'hB3, 2, 2, 64'hCE, 1'b0));
    stim8.push_back(mk(64'hB3, 2, 3, 64'hEC, 1'b1));
    stim8.push_back(mk(64'hB3, 2, 4, 64'hEC, 1'b1));
    stim8.push_back(mk(64'h80, 7, 4, 64'hFF, 1'b0));
    stim8.push_back(mk(64'h80, 7, 1, 64'h01, 1'b0));
    stim8.push_back(mk(64'h80, 0, 3, 64'h80, 1'b0));
    stim8.push_back(mk(64'h80, 5, 6, 64'h80, 1'b0));
    stim8.push_back(mk(64'h02, 7, 0, 64'h00, 1'b1));
    for (int i = 0; i < 40 && (stim8.size() > 0 || exp8.size() > 0 || iv8); i++) tick8();
    check("directed_outputs8", 64'(outs8), 64'd10);
    check("directed_pending8", 64'(exp8.size() + stim8.size()), 64'd0);

    // Backpressure: 5 beats offered, only 3 fit
    lat8 = 1'b0; or8 = 1'b0; outs8 = 0; accs8 = 0;
    stim8.push_back(mk(64'h81, 1, 2, 64'h03, 1'b1));
    stim8.push_back(mk(64'h42, 1, 2, 64'h84, 1'b0));
    stim8.push_back(mk(64'h23, 1, 2, 64'h46, 1'b0));
    stim8.push_back(mk(64'h14, 1, 2, 64'h28, 1'b0));
    stim8.push_back(mk(64'h05, 1, 2, 64'h0A, 1'b0));
    repeat (6) tick8();
    check("bp_accepted8", 64'(accs8), 64'd3);
    check("bp_in_ready8", 64'(ir8), 64'd0);
    check("bp_out_valid8", 64'(ov8), 64'd1);
    check("bp_out_data8", 64'(od8), 64'h03);
    repeat (4) tick8();
    check("bp_still_accepted8", 64'(accs8), 64'd3);
    check("bp_out_data_stable8", 64'(od8), 64'h03);
    or8 = 1'b1;
    for (int i = 0; i < 40 && (stim8.size() > 0 || exp8.size() > 0 || iv8); i++) tick8();
    check("bp_outputs8", 64'(outs8), 64'd5);
    check("bp_pending8", 64'(exp8.size() + stim8.size()), 64'd0);

    // Reset with 3 beats in flight
    or8 = 1'b0; accs8 = 0;
    stim8.push_back(mk(64'h01, 1, 0, 64'h02, 1'b0));
    stim8.push_back(mk(64'h02, 1, 0, 64'h04, 1'b0));
    stim8.push_back(mk(64'h03, 1, 0, 64'h06, 1'b0));
    repeat (3) tick8();
    check("inflight_accepted8", 64'(accs8), 64'd3);
    stim8.delete();
    iv8 = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready8", 64'(ir8), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_out_valid8", 64'(ov8), 64'd0);
    check("post_rst_out_data8", 64'(od8), 64'd0);
    #1;
    check("post_rst_in_ready8", 64'(ir8), 64'd1);
    exp8.delete();
    or8 = 1'b1; outs8 = 0;
    repeat (6) tick8();
    check("post_rst_no_ghosts8", 64'(outs8), 64'd0);

    // WIDTH=32: full rate, out_ready=1, latency 5
    or32 = 1'b1; rnd32 = 1'b0; lat32 = 1'b1; left32 = 30;
    for (int i = 0; i < 200 && (left32 > 0 || exp32.size() > 0 || iv32); i++) tick32();
    check("full_rate_outputs32", 64'(outs32), 64'd30);
    check("full_rate_pending32", 64'(exp32.size() + left32), 64'd0);

    // WIDTH=32: random gaps and random out_ready
    rnd32 = 1'b1; lat32 = 1'b0; left32 = 150; outs32 = 0; accs32 = 0;
    for (int i = 0; i < 3000 && (left32 > 0 || exp32.size() > 0 || iv32); i++) tick32();
    check("random_pending32", 64'(exp32.size() + left32), 64'd0);
    check("random_outputs32", 64'(outs32), 64'd150);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
